rect_filler: RTL

Upstream drawing engine for the pixel writer. Accepts one filled-rectangle command at a time (origin, width, height, colour) and walks it row-major, issuing one pixel request per pixel on the pixel writer's pixel_en / pixel_wr_done handshake. Commands are only accepted after the boot-time screen clear has finished. It replaces the pixel test pattern generator as the pixel writer's producer and is the draw path the processor's rectangle operations will use.

---
 rtl/rect_filler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rect_filler.sv
// rect_filler: walks one filled-rectangle command row-major, one pixel_en per pixel.
// Optional clipping to SCREEN_W x SCREEN_H is enabled with `define RECT_CLIP_EN.
module rect_filler #(
  parameter int SCREEN_W = 256,
  parameter int SCREEN_H = 192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_screen_done,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x0,
  input  logic [7:0] cmd_y0,
  input  logic [7:0] cmd_w,
  input  logic [7:0] cmd_h,
  input  logic [7:0] cmd_rgb,
  output logic       busy,
  output logic       done,
  output logic       pixel_en,
  output logic [7:0] pixel_x,
  output logic [7:0] pixel_y,
  output logic [7:0] pixel_rgb,
  input  logic       pixel_wr_done
);

`ifdef RECT_CLIP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, SKIP = 2'd3} state_t;
  localparam int TW = 9;
  localparam logic [8:0] SCR_W_C = 9'(SCREEN_W);
  localparam logic [8:0] SCR_H_C = 9'(SCREEN_H);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
  localparam int TW = 8;
  localparam logic [17:0] unused_dims_c = {9'(SCREEN_W), 9'(SCREEN_H)};
`endif

  state_t        state_r, state_s, run_s;
  logic [7:0]    x0_r, y0_r, w_r, h_r, rgb_r, cx_r, cy_r;
  logic [7:0]    nx_cx_s, nx_cy_s;
  logic [TW-1:0] tgt_x_s, tgt_y_s;
  logic          last_s, accept_s, step_s, done_s;
  logic          rdy_r, busy_r, done_r, pixel_en_r;
  logic [7:0]    pixel_x_r, pixel_y_r, pixel_rgb_r;

  assign cmd_ready = rdy_r & clear_screen_done;
  assign accept_s  = cmd_valid & cmd_ready;
  assign step_s    = ((state_r == WAIT) && pixel_wr_done)
`ifdef RECT_CLIP_EN
                     || (state_r == SKIP)
`endif
                     ;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pixel_en  = pixel_en_r;
  assign pixel_x   = pixel_x_r;
  assign pixel_y   = pixel_y_r;
  assign pixel_rgb = pixel_rgb_r;

  // Next offsets and the coordinates of the pixel about to be visited
  always_comb begin
    nx_cx_s = cx_r + 8'd1;
    nx_cy_s = cy_r;
    if (nx_cx_s == w_r) begin
      nx_cx_s = 8'd0;
      nx_cy_s = cy_r + 8'd1;
    end else begin
      nx_cy_s = cy_r;
    end
    last_s = (nx_cx_s == 8'd0) && (nx_cy_s == h_r);
    if (state_r == IDLE) begin
      tgt_x_s = TW'(cmd_x0);
      tgt_y_s = TW'(cmd_y0);
    end else begin
      tgt_x_s = TW'(x0_r) + TW'(nx_cx_s);
      tgt_y_s = TW'(y0_r) + TW'(nx_cy_s);
    end
`ifdef RECT_CLIP_EN
    run_s = ((tgt_x_s >= SCR_W_C) || (tgt_y_s >= SCR_H_C)) ? SKIP : ISSUE;
`else
    run_s = ISSUE;
`endif
  end

  // Next-state and done decode
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if ((cmd_w == 8'd0) || (cmd_h == 8'd0)) begin
            done_s = 1'b1;
          end else begin
            state_s = run_s;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      default: begin
        if (step_s) begin
          if (last_s) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = run_s;
          end
        end else if (state_r == WAIT) begin
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rdy_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pixel_en_r  <= 1'b0;
      pixel_x_r   <= 8'd0;
      pixel_y_r   <= 8'd0;
      pixel_rgb_r <= 8'd0;
    end else begin
      state_r    <= state_s;
      rdy_r      <= (state_s == IDLE);
      busy_r     <= (state_s != IDLE);
      done_r     <= done_s;
      pixel_en_r <= (state_s == ISSUE);
      if (state_s == ISSUE) begin
        pixel_x_r   <= tgt_x_s[7:0];
        pixel_y_r   <= tgt_y_s[7:0];
        pixel_rgb_r <= (state_r == IDLE) ? cmd_rgb : rgb_r;
      end else begin
        pixel_x_r   <= pixel_x_r;
        pixel_y_r   <= pixel_y_r;
        pixel_rgb_r <= pixel_rgb_r;
      end
    end
  end

  // Command latch and row-major offset counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_r  <= 8'd0;
      y0_r  <= 8'd0;
      w_r   <= 8'd0;
      h_r   <= 8'd0;
      rgb_r <= 8'd0;
      cx_r  <= 8'd0;
      cy_r  <= 8'd0;
    end else if (accept_s) begin
      x0_r  <= cmd_x0;
      y0_r  <= cmd_y0;
      w_r   <= cmd_w;
      h_r   <= cmd_h;
      rgb_r <= cmd_rgb;
      cx_r  <= 8'd0;
      cy_r  <= 8'd0;
    end else if (step_s) begin
      cx_r <= nx_cx_s;
      cy_r <= nx_cy_s;
    end else begin
      cx_r <= cx_r;
      cy_r <= cy_r;
    end
  end

endmodule
